ofm_axi_wmst: RTL and testbench

- AXI4 write master directly downstream of the OFM flattening stage.
- Accepts a transfer request of {base address, byte size} plus a 512-bit stream of OFM words.
- Splits the transfer into AXI4 INCR bursts that never cross a 4 KB boundary, writes them to device memory and reports completion with a one-cycle done pulse.
- Allows one burst outstanding at a time.

---
 rtl/ofm_axi_pkg.sv | 20 ++
 rtl/wmst_burst_calc.sv | 16 +
 rtl/ofm_axi_wmst.sv | 155 +++++++++++++++
 tb/tb_ofm_axi_wmst.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_axi_pkg.sv
// rtl/ofm_axi_pkg.sv - shared AXI constants and FSM encoding for the OFM write master
package ofm_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_64B   = 3'b110;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int BEAT_BYTES = 64;
  localparam int BEAT_SHIFT = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } wmst_state_e;

endpackage

// File: rtl/wmst_burst_calc.sv
// rtl/wmst_burst_calc.sv - burst length = min(remaining beats, MAX_BURST, beats to next 4 KB boundary)
module wmst_burst_calc #(
  parameter int MAX_BURST = 16
) (
  input  logic [57:0] remaining,
  input  logic [6:0]  to_4k,
  output logic [8:0]  len
);

  always_comb begin
    len = 9'(MAX_BURST);
    if ({2'b00, to_4k} < len) len = {2'b00, to_4k};
    if (remaining < 58'(len)) len = remaining[8:0];
  end

endmodule

// File: rtl/ofm_axi_wmst.sv
// rtl/ofm_axi_wmst.sv - AXI4 write master splitting an OFM stream into 4 KB-safe INCR bursts
module ofm_axi_wmst
  import ofm_axi_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 64,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [63:0]         req_size,
  output logic                done,
  output logic                busy,
  output logic                err,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  wmst_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [57:0]        remaining_q, remaining_d;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic [7:0]         awlen_q, awlen_d;
  logic [7:0]         beat_q, beat_d;
  logic               err_q, err_d;
  logic [6:0]         to_4k;
  logic [8:0]         len;
  logic [8:0]         burst_len;
  logic               unused_size_lsb;

  assign unused_size_lsb = ^req_size[5:0];

  // Addresses are beat aligned, so the distance to the boundary is a whole number of beats.
  assign to_4k     = 7'((13'h1000 - {1'b0, cur_addr_q[11:0]}) >> BEAT_SHIFT);
  assign burst_len = {1'b0, awlen_q} + 9'd1;

  wmst_burst_calc #(.MAX_BURST(MAX_BURST)) u_calc (
    .remaining (remaining_q),
    .to_4k     (to_4k),
    .len       (len)
  );

  assign m_awaddr  = awaddr_q;
  assign m_awlen   = awlen_q;
  assign m_awsize  = SIZE_64B;
  assign m_awburst = BURST_INCR;
  assign m_wdata   = s_tdata;
  assign m_wstrb   = '1;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    beat_d      = beat_q;
    err_d       = err_q;
    done        = 1'b0;
    s_tready    = 1'b0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_wlast     = 1'b0;
    m_bready    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          cur_addr_d  = req_addr;
          remaining_d = req_size[63:6];
          err_d       = 1'b0;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        // Zero-size requests are recognised here, once the latched size is available.
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else begin
          awaddr_d = cur_addr_q;
          awlen_d  = 8'(len - 9'd1);
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) begin
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        m_wvalid = s_tvalid;
        s_tready = m_wready;
        m_wlast  = (beat_q == awlen_q);
        if (s_tvalid && m_wready) begin
          beat_d = beat_q + 8'd1;
          if (m_wlast) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          err_d       = err_q | (m_bresp != RESP_OKAY);
          cur_addr_d  = cur_addr_q + (ADDR_W'(burst_len) << BEAT_SHIFT);
          remaining_d = remaining_q - 58'(burst_len);
          state_d     = (remaining_d == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_ofm_axi_wmst.sv
// tb/tb_ofm_axi_wmst.sv - directed self-checking bench for ofm_axi_wmst
module tb_ofm_axi_wmst;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [63:0]  req_addr;
  logic [63:0]  req_size;
  logic         done, busy, err;
  logic [511:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic [63:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_awvalid;
  logic         m_awready;
  logic [511:0] m_wdata;
  logic [63:0]  m_wstrb;
  logic         m_wlast;
  logic         m_wvalid;
  logic         m_wready;
  logic [1:0]   m_bresp;
  logic         m_bvalid;
  logic         m_bready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ofm_axi_wmst dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_size(req_size),
    .done(done), .busy(busy), .err(err),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [63:0] addr, input logic [63:0] size);
    req      = 1'b1;
    req_addr = addr;
    req_size = size;
    tick();
    req      = 1'b0;
  endtask

  task automatic aw_phase(input logic [63:0] exp_addr, input logic [7:0] exp_len, input int delay);
    int n = 0;
    while (!m_awvalid && n < 50) begin
      tick();
      n++;
    end
    chk("aw_seen", m_awvalid, 1);
    s_tvalid = 1'b1;
    for (int i = 0; i < delay; i++) begin
      #1;
      chk("aw_hold_valid", m_awvalid, 1);
      chk("aw_hold_addr", m_awaddr, exp_addr);
      chk("aw_hold_len", m_awlen, exp_len);
      chk("w_before_aw", m_wvalid, 0);
      tick();
    end
    s_tvalid = 1'b0;
    chk("awaddr", m_awaddr, exp_addr);
    chk("awlen", m_awlen, exp_len);
    chk("awsize", m_awsize, 3'b110);
    chk("awburst", m_awburst, 2'b01);
    m_awready = 1'b1;
    tick();
    m_awready = 1'b0;
  endtask

  task automatic w_phase(input int nsend, input int last_idx, input int base, input bit gaps);
    logic [31:0] word;
    int b = 0;
    int guard = 0;
    while (b < nsend && guard < 2000) begin
      word     = 32'(base + b);
      s_tdata  = {16{word}};
      s_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      m_wready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("wvalid_pass", m_wvalid, s_tvalid);
      chk("tready_pass", s_tready, m_wready);
      if (s_tvalid && m_wready) begin
        total++;
        assert (m_wdata === {16{word}}) else begin
          bad++;
          $error("FAIL wdata: observed=%0h expected=%0h", m_wdata[31:0], word);
        end
        chk("wlast", m_wlast, (b == last_idx));
        chk("wstrb", m_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
        b++;
      end
      tick();
      guard++;
    end
    chk("w_beats_sent", 64'(b), 64'(nsend));
    s_tvalid = 1'b0;
    m_wready = 1'b0;
  endtask

  task automatic b_phase(input logic [1:0] resp);
    int n = 0;
    while (!m_bready && n < 50) begin
      tick();
      n++;
    end
    chk("bready", m_bready, 1);
    m_bvalid = 1'b1;
    m_bresp  = resp;
    tick();
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; req_addr = '0; req_size = '0;
    s_tdata = '0; s_tvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_bresp = 2'b00; m_bvalid = 1'b0;
    repeat (2) tick();
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_awlen", m_awlen, 0);
    chk("rst_bready", m_bready, 0);
    rst_n = 1'b1;
    tick();

    // single 16-beat burst
    start(64'h1000, 64'd1024);
    chk("t1_busy", busy, 1);
    chk("t1_awvalid_calc", m_awvalid, 0);
    tick();
    chk("t1_awvalid_t2", m_awvalid, 1);
    aw_phase(64'h1000, 8'd15, 0);
    w_phase(16, 15, 0, 1'b0);
    b_phase(2'b00);
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_busy_done", busy, 1);
    tick();
    chk("t1_done_clr", done, 0);
    chk("t1_busy_clr", busy, 0);

    // 4 KB boundary split
    start(64'h0FC0, 64'd1024);
    aw_phase(64'h0FC0, 8'd0, 0);
    w_phase(1, 0, 100, 1'b0);
    b_phase(2'b00);
    chk("t2_no_early_done", done, 0);
    aw_phase(64'h1000, 8'd14, 0);
    w_phase(15, 14, 101, 1'b0);
    b_phase(2'b00);
    chk("t2_done", done, 1);
    tick();
    chk("t2_done_once", done, 0);

    // four bursts with backpressure and delayed AW ready
    start(64'h0, 64'd4096);
    for (int i = 0; i < 4; i++) begin
      aw_phase(64'(i * 'h400), 8'd15, 5);
      w_phase(16, 15, 200 + i * 16, 1'b1);
      b_phase(2'b00);
      chk("t3_done", done, (i == 3));
    end
    tick();

    // error response on the first of two bursts
    start(64'h1FC0, 64'd128);
    aw_phase(64'h1FC0, 8'd0, 0);
    w_phase(1, 0, 300, 1'b0);
    b_phase(2'b10);
    chk("t4_err_set", err, 1);
    aw_phase(64'h2000, 8'd0, 0);
    w_phase(1, 0, 301, 1'b0);
    b_phase(2'b00);
    chk("t4_done", done, 1);
    chk("t4_err_sticky", err, 1);
    tick();
    chk("t4_err_after", err, 1);
    start(64'h3000, 64'd64);
    chk("t4_err_clear", err, 0);
    aw_phase(64'h3000, 8'd0, 0);
    w_phase(1, 0, 302, 1'b0);
    b_phase(2'b00);
    chk("t4_done2", done, 1);
    chk("t4_err2", err, 0);
    tick();

    // zero size request
    start(64'h0, 64'd63);
    chk("t5_zero_done_t1", done, 0);
    chk("t5_zero_aw_t1", m_awvalid, 0);
    tick();
    chk("t5_zero_done_t2", done, 1);
    chk("t5_zero_aw_t2", m_awvalid, 0);
    tick();
    chk("t5_zero_idle", busy, 0);

    // req while busy is ignored
    start(64'h4000, 64'd64);
    req = 1'b1; req_addr = 64'h8000; req_size = 64'd1024;
    aw_phase(64'h4000, 8'd0, 2);
    req = 1'b0;
    w_phase(1, 0, 400, 1'b0);
    b_phase(2'b00);
    chk("t5_busy_done", done, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_extra_aw", m_awvalid, 0);
    end

    // reset in the middle of a data burst
    start(64'h5000, 64'd1024);
    aw_phase(64'h5000, 8'd15, 0);
    w_phase(5, 15, 500, 1'b0);
    s_tvalid = 1'b1;
    m_wready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_tready", s_tready, 0);
    chk("t6_wvalid", m_wvalid, 0);
    chk("t6_wlast", m_wlast, 0);
    chk("t6_awaddr", m_awaddr, 0);
    chk("t6_awlen", m_awlen, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t6_no_done", done, 0);
    end
    s_tvalid = 1'b0;
    m_wready = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("t6_idle_done", done, 0);
    start(64'h6000, 64'd64);
    aw_phase(64'h6000, 8'd0, 0);
    w_phase(1, 0, 600, 1'b0);
    b_phase(2'b00);
    chk("t6_recover_done", done, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
